nyq_interp: RTL and testbench

NYQ_INTERP -- requirements
Module: nyq_interp

---
 rtl/nyq_interp_pkg.sv | 25 ++
 rtl/nyq_interp_if.sv | 33 +++
 rtl/nyq_dot4.sv | 27 ++
 rtl/nyq_interp.sv | 118 +++++++++++
 tb/tb_nyq_interp.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nyq_interp_pkg.sv
// Shared constants, FSM state encoding and rounding helper for the 1:8 Nyquist
// interpolator (nyq_interp) and its 4-tap dot-product datapath (nyq_dot4).
package nyq_pkg;

  localparam int NUM_PHASES     = 8;
  localparam int TAPS_PER_PHASE = 4;
  localparam int ACC_WIDTH      = 50;
  localparam int ROUND_SHIFT    = 23;
  localparam int PHASE_BITS     = $clog2(NUM_PHASES);

  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_RUN  = 1'b1;

  localparam logic signed [ACC_WIDTH-1:0] ROUND_BIAS =
    {{(ACC_WIDTH-ROUND_SHIFT){1'b0}}, 1'b1, {(ROUND_SHIFT-1){1'b0}}};

  // Round half up, then drop the fractional bits of the Q-format product sum.
  function automatic logic signed [ACC_WIDTH-1:0] round_half_up(
    input logic signed [ACC_WIDTH-1:0] s
  );
    return (s + ROUND_BIAS) >>> ROUND_SHIFT;
  endfunction

endpackage

// File: rtl/nyq_interp_if.sv
// Low-rate sample input and high-rate sample output of nyq_interp, grouped as
// one bundle; master = sample producer/consumer, slave = the interpolator.
interface nyq_interp_if #(
  parameter int IN_WIDTH  = 24,
  parameter int OUT_WIDTH = 24
);

  // Handshake: a sample transfers on a rising edge where NYQI_Valid_SI and
  // NYQI_Ready_SO are both 1; the producer holds NYQI_In_DI and NYQI_Valid_SI
  // stable until then. NYQI_Valid_DO has no back-pressure.
  logic [IN_WIDTH-1:0]  NYQI_In_DI;
  logic                 NYQI_Valid_SI;
  logic                 NYQI_Ready_SO;
  logic [OUT_WIDTH-1:0] NYQI_Out_DO;
  logic                 NYQI_Valid_DO;

  modport master (
    output NYQI_In_DI,
    output NYQI_Valid_SI,
    input  NYQI_Ready_SO,
    input  NYQI_Out_DO,
    input  NYQI_Valid_DO
  );

  modport slave (
    input  NYQI_In_DI,
    input  NYQI_Valid_SI,
    output NYQI_Ready_SO,
    output NYQI_Out_DO,
    output NYQI_Valid_DO
  );

endinterface

// File: rtl/nyq_dot4.sv
// Combinational 4-tap signed multiply-add at full precision: one polyphase
// branch of the interpolator.
module nyq_dot4
  import nyq_pkg::*;
#(
  parameter int COEF_WIDTH = 24,
  parameter int SAMP_WIDTH = 24
) (
  input  logic signed [COEF_WIDTH-1:0] Coef_DI [TAPS_PER_PHASE],
  input  logic signed [SAMP_WIDTH-1:0] Samp_DI [TAPS_PER_PHASE],
  output logic signed [ACC_WIDTH-1:0]  Sum_DO
);

  localparam int PROD_WIDTH = COEF_WIDTH + SAMP_WIDTH;

  logic signed [PROD_WIDTH-1:0] prod [TAPS_PER_PHASE];

  always_comb begin
    prod   = '{default: '0};
    Sum_DO = '0;
    for (int i = 0; i < TAPS_PER_PHASE; i++) begin
      prod[i] = PROD_WIDTH'(Coef_DI[i]) * PROD_WIDTH'(Samp_DI[i]);
      Sum_DO  = Sum_DO + ACC_WIDTH'(prod[i]);
    end
  end

endmodule

// File: rtl/nyq_interp.sv
// 1:8 polyphase interpolating Nyquist filter, 32-tap writable coefficient memory.
// Define NYQ_INTERP_SAT_EN to saturate the output; otherwise it wraps.
module nyq_interp
  import nyq_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int MEM_WIDTH  = 24,
  parameter int IN_WIDTH   = 24,
  parameter int OUT_WIDTH  = 24
) (
  input  logic                  Clk_CI,
  input  logic                  Rst_RI,
  input  logic                  WrEn_SI,
  input  logic [ADDR_WIDTH-1:0] Addr_DI,
  input  logic [MEM_WIDTH-1:0]  PAR_In_DI,
  nyq_interp_if.slave           nyqi,
  output state_t                Dbg_State_SO,
  output logic [PHASE_BITS-1:0] Dbg_Phase_DO
);

  localparam int DEPTH   = 2 ** ADDR_WIDTH;
  localparam int Y_WIDTH = ACC_WIDTH - ROUND_SHIFT;

  state_t                       state_q;
  logic [PHASE_BITS-1:0]        phase_q;
  logic signed [MEM_WIDTH-1:0]  coef_q  [DEPTH];
  logic signed [IN_WIDTH-1:0]   dline_q [TAPS_PER_PHASE];
  logic [OUT_WIDTH-1:0]         out_q;
  logic                         out_valid_q;

  logic                         last_phase;
  logic                         ready;
  logic                         accept;
  logic signed [MEM_WIDTH-1:0]  tap_coef [TAPS_PER_PHASE];
  logic signed [ACC_WIDTH-1:0]  acc_sum;
  logic [OUT_WIDTH-1:0]         y_out;

  assign last_phase = (phase_q == PHASE_BITS'(NUM_PHASES - 1));
  assign ready      = !Rst_RI && ((state_q == ST_IDLE) || last_phase);
  assign accept     = ready && nyqi.NYQI_Valid_SI;

  // Phase p reads taps h[p], h[p+8], h[p+16], h[p+24] against x0..x3.
  always_comb begin
    tap_coef = '{default: '0};
    for (int i = 0; i < TAPS_PER_PHASE; i++) begin
      tap_coef[i] = coef_q[ADDR_WIDTH'(i * NUM_PHASES) + ADDR_WIDTH'(phase_q)];
    end
  end

  nyq_dot4 #(
    .COEF_WIDTH (MEM_WIDTH),
    .SAMP_WIDTH (IN_WIDTH)
  ) u_dot4 (
    .Coef_DI (tap_coef),
    .Samp_DI (dline_q),
    .Sum_DO  (acc_sum)
  );

`ifdef NYQ_INTERP_SAT_EN
  logic signed [Y_WIDTH-1:0]     y_full;
  logic [Y_WIDTH-OUT_WIDTH:0]    y_top;

  assign y_full = Y_WIDTH'(round_half_up(acc_sum));
  assign y_top  = y_full[Y_WIDTH-1:OUT_WIDTH-1];

  // Out of range when the bits above the output sign are not a sign extension.
  always_comb begin
    y_out = y_full[OUT_WIDTH-1:0];
    if (!((&y_top) || !(|y_top))) begin
      y_out = y_top[Y_WIDTH-OUT_WIDTH] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                       : {1'b0, {(OUT_WIDTH-1){1'b1}}};
    end
  end
`else
  assign y_out = OUT_WIDTH'(round_half_up(acc_sum));
`endif

  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      state_q     <= ST_IDLE;
      phase_q     <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) coef_q[i] <= '0;
      for (int i = 0; i < TAPS_PER_PHASE; i++) dline_q[i] <= '0;
    end else begin
      if (WrEn_SI) coef_q[Addr_DI] <= PAR_In_DI;

      if (accept) begin
        dline_q[0] <= nyqi.NYQI_In_DI;
        for (int i = 1; i < TAPS_PER_PHASE; i++) dline_q[i] <= dline_q[i-1];
      end

      out_valid_q <= (state_q == ST_RUN);
      if (state_q == ST_RUN) out_q <= y_out;

      // A new sample at phase 7 restarts the block with no idle cycle.
      if (state_q == ST_IDLE) begin
        if (accept) begin
          state_q <= ST_RUN;
          phase_q <= '0;
        end
      end else if (last_phase) begin
        phase_q <= '0;
        if (!accept) state_q <= ST_IDLE;
      end else begin
        phase_q <= phase_q + 1'b1;
      end
    end
  end

  assign nyqi.NYQI_Ready_SO = ready;
  assign nyqi.NYQI_Out_DO   = out_q;
  assign nyqi.NYQI_Valid_DO = out_valid_q;
  assign Dbg_State_SO       = state_q;
  assign Dbg_Phase_DO       = phase_q;

endmodule

// File: tb/tb_nyq_interp.sv
// Bench for nyq_interp: randomized and directed samples, reference model of the
// interpolation arithmetic, scoreboard checked by an independent output monitor.
module tb_nyq_interp;
  import nyq_pkg::*;

  localparam int AW   = 5;
  localparam int W    = 24;
  localparam int NTAP = 32;
`ifdef NYQ_INTERP_SAT_EN
  localparam logic [W-1:0] OVF_EXP = 24'h7FFFFF;
`else
  localparam logic [W-1:0] OVF_EXP = 24'hFFFFF8;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic          clk    = 1'b0;
  logic          rst    = 1'b1;
  logic          wr_en  = 1'b0;
  logic [AW-1:0] addr   = '0;
  logic [W-1:0]  par_in = '0;
  state_t        dbg_state;
  logic [2:0]    dbg_phase;

  nyq_interp_if #(.IN_WIDTH(W), .OUT_WIDTH(W)) nyqi ();

  nyq_interp #(
    .ADDR_WIDTH (AW),
    .MEM_WIDTH  (W),
    .IN_WIDTH   (W),
    .OUT_WIDTH  (W)
  ) dut (
    .Clk_CI       (clk),
    .Rst_RI       (rst),
    .WrEn_SI      (wr_en),
    .Addr_DI      (addr),
    .PAR_In_DI    (par_in),
    .nyqi         (nyqi),
    .Dbg_State_SO (dbg_state),
    .Dbg_Phase_DO (dbg_phase)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- bookkeeping ----------------
  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- reference model ----------------
  longint h_m [NTAP];
  longint x_m [4];
  longint acc_edge = -1000;

  initial begin
    for (int i = 0; i < NTAP; i++) h_m[i] = 0;
    for (int i = 0; i < 4; i++) x_m[i] = 0;
  end

  function automatic longint sx(input logic [W-1:0] v);
    return {{(64-W){v[W-1]}}, v};
  endfunction

  // y for phase p; coefficient ov_a (if >= 0) replaced by ov_d.
  function automatic logic [W-1:0] model_y(input int p, input int ov_a, input longint ov_d);
    longint s = 0;
    longint c;
    longint y;
    for (int i = 0; i < 4; i++) begin
      c = (p + 8 * i == ov_a) ? ov_d : h_m[p + 8 * i];
      s += c * x_m[i];
    end
    y = (s + 64'sd4194304) >>> 23;
`ifdef NYQ_INTERP_SAT_EN
    if (y > 64'sd8388607) y = 64'sd8388607;
    else if (y < -64'sd8388608) y = -64'sd8388608;
`endif
    return y[W-1:0];
  endfunction

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q [$];
  longint       due_q [$];
  logic [W-1:0] hold_val = '0;
  logic [W-1:0] last_out = '0;
  bit           mon_en   = 1'b0;
  int           run_len  = 0;
  int           max_run  = 0;

  initial begin
    logic r;
    logic [W-1:0] e;
    longint d;
    forever begin
      @(posedge clk);
      r = rst;
      @(negedge clk);
      if (!mon_en) continue;
      if (r) begin
        // outputs due at or after the reset edge belong to the aborted block
        while (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          d = due_q.pop_front();
          if (d < cyc) check("missing_out", 64'(d), 64'(cyc));
        end
        hold_val = '0;
        run_len  = 0;
        continue;
      end
      if (nyqi.NYQI_Valid_DO) begin
        run_len++;
        if (run_len > max_run) max_run = run_len;
        if (exp_q.size() == 0) begin
          check("unexpected_out", 64'(nyqi.NYQI_Out_DO), 64'hDEAD);
        end else begin
          e = exp_q.pop_front();
          d = due_q.pop_front();
          check("out_data", 64'(nyqi.NYQI_Out_DO), 64'(e));
          check("out_timing", 64'(cyc), 64'(d));
          hold_val = e;
          last_out = nyqi.NYQI_Out_DO;
        end
      end else begin
        run_len = 0;
        check("out_hold", 64'(nyqi.NYQI_Out_DO), 64'(hold_val));
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [W-1:0] rnd_sample();
    case ($urandom_range(0, 4))
      0:       return 24'h7FFFFF;
      1:       return 24'h800000;
      default: return W'($urandom);
    endcase
  endfunction

  task automatic write_coef(input int a, input logic [W-1:0] d);
    wr_en  = 1'b1;
    addr   = AW'(a);
    par_in = d;
    @(posedge clk);
    #1;
    wr_en  = 1'b0;
    h_m[a] = sx(d);
  endtask

  // Present one sample and hold it until accepted; a planned write of
  // wr_d to wr_a lands before phase wr_ph of the resulting block.
  task automatic send(input logic [W-1:0] d, input int wr_ph = -1,
                      input int wr_a = -1, input logic [W-1:0] wr_d = '0);
    bit done = 1'b0;
    nyqi.NYQI_In_DI    = d;
    nyqi.NYQI_Valid_SI = 1'b1;
    for (int t = 0; t < 64 && !done; t++) begin
      @(negedge clk);
      check("ready", 64'(nyqi.NYQI_Ready_SO), 64'((cyc - acc_edge) >= 7));
      if (nyqi.NYQI_Ready_SO) begin
        acc_edge = cyc + 1;
        x_m[3] = x_m[2];
        x_m[2] = x_m[1];
        x_m[1] = x_m[0];
        x_m[0] = sx(d);
        for (int p = 0; p < 8; p++) begin
          exp_q.push_back(model_y(p, (wr_ph >= 0 && p >= wr_ph) ? wr_a : -1, sx(wr_d)));
          due_q.push_back(acc_edge + 1 + p);
        end
        done = 1'b1;
      end
    end
    if (!done) check("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    nyqi.NYQI_Valid_SI = 1'b0;
    nyqi.NYQI_In_DI    = W'($urandom);
  endtask

  task automatic drain();
    for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(negedge clk);
    check("drain", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    longint a_edge;
    nyqi.NYQI_Valid_SI = 1'b0;
    nyqi.NYQI_In_DI    = '0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 64'(nyqi.NYQI_Valid_DO), 64'd0);
    check("rst_out", 64'(nyqi.NYQI_Out_DO), 64'd0);
    check("rst_ready", 64'(nyqi.NYQI_Ready_SO), 64'd0);
    check("rst_phase", 64'(dbg_phase), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    check("idle_ready", 64'(nyqi.NYQI_Ready_SO), 64'd1);
    check("idle_valid", 64'(nyqi.NYQI_Valid_DO), 64'd0);
    @(posedge clk);
    #1;

    // impulse: 32 outputs of 0x200000 then a block of zeros
    for (int a = 0; a < NTAP; a++) write_coef(a, 24'h400000);
    send(24'h400000);
    repeat (4) send(24'h000000);
    drain();

    // gapless stream with random coefficients
    for (int a = 0; a < NTAP; a++) write_coef(a, W'($urandom));
    max_run = 0;
    repeat (6) send(rnd_sample());
    drain();
    check("gapless_run", 64'(max_run >= 16), 64'd1);

    // overflow
    for (int a = 0; a < NTAP; a++) write_coef(a, 24'h7FFFFF);
    repeat (4) send(24'h7FFFFF);
    drain();
    check("ovf_last", 64'(last_out), 64'(OVF_EXP));

    // backpressure: sample presented at p=2 waits for p=7
    for (int a = 0; a < NTAP; a++) write_coef(a, W'($urandom));
    send(rnd_sample());
    a_edge = acc_edge;
    idle(2);
    send(rnd_sample());
    check("bp_accept_edge", 64'(acc_edge), 64'(a_edge + 8));
    drain();

    // live coefficient write at p=4 affects p=5
    send(24'h3A5C71, 5, 5, 24'h100000);
    idle(4);
    wr_en  = 1'b1;
    addr   = AW'(5);
    par_in = 24'h100000;
    @(posedge clk);
    #1;
    wr_en  = 1'b0;
    h_m[5] = sx(24'h100000);
    drain();

    // random traffic with idle gaps and coefficient updates
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 5) == 0) begin
        drain();
        repeat (4) write_coef(int'($urandom_range(0, NTAP - 1)), W'($urandom));
      end
      send(rnd_sample());
      idle(int'($urandom_range(0, 10)));
    end
    drain();

    // reset mid-block at p=3
    for (int a = 0; a < NTAP; a++) write_coef(a, W'($urandom));
    send(rnd_sample());
    idle(3);
    rst = 1'b1;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_valid", 64'(nyqi.NYQI_Valid_DO), 64'd0);
    check("mid_rst_out", 64'(nyqi.NYQI_Out_DO), 64'd0);
    check("mid_rst_ready", 64'(nyqi.NYQI_Ready_SO), 64'd0);
    for (int i = 0; i < NTAP; i++) h_m[i] = 0;
    for (int i = 0; i < 4; i++) x_m[i] = 0;
    acc_edge = -1000;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);
    // cleared coefficients read back as zeros through an impulse
    send(24'h400000);
    repeat (3) send(24'h000000);
    drain();
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time budget at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
